// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM word, RAM handshake status and the memory arbiter
// state encoding.
package cpu_types_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned STARVE_W = 3;

    typedef logic [WORD_W-1:0] word_t;

    // RAM status reported back to the arbiter every cycle
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Arbiter ownership; the encoding is exported on the owner port
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one RAM port between an instruction fetch side and
// a data load/store side.
//   CLK, nRST            clock, asynchronous active-low reset
//   iREN/iaddr           instruction read request / word address
//   iwait/iload          instruction stall / fetched word (valid when iwait low)
//   dREN/dWEN            data read / write request
//   daddr/dstore         data address / write value
//   dwait/dload          data stall / read value (valid when dwait low)
//   ramREN/ramWEN        RAM strobes
//   ramaddr/ramstore     RAM address / write data
//   ramload/ramstate     RAM read data / RAM status
//   owner                current arbiter state encoding
// Data requests win arbitration; after STARVE_MAX consecutive data grants
// made while a fetch is pending, the fetch is forced through.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  word_t       iaddr,
    output logic        iwait,
    output word_t       iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  word_t       daddr,
    input  word_t       dstore,
    output logic        dwait,
    output word_t       dload,
    output logic        ramREN,
    output logic        ramWEN,
    output word_t       ramaddr,
    output word_t       ramstore,
    input  word_t       ramload,
    input  ramstate_t   ramstate,
    output logic [1:0]  owner
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    arb_state_t            r_state;
    arb_state_t            w_next_state;
    logic [STARVE_W-1:0]   r_starve_cnt;
    logic                  w_dreq;
    logic                  w_access;
    logic                  w_starved;

    assign w_dreq    = dREN | dWEN;
    assign w_access  = (ramstate == ACCESS);
    assign w_starved = iREN && (r_starve_cnt == STARVE_LIM);

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: every grant returns through IDLE, so a request that is
    // still asserted after completion is never granted back-to-back.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_dreq && !w_starved) begin
                    w_next_state = DGRANT;
                end else if (iREN) begin
                    w_next_state = IGRANT;
                end else begin
                    w_next_state = IDLE;
                end
            end
            IGRANT: begin
                if (!iREN || w_access) begin
                    w_next_state = IDLE;
                end
            end
            DGRANT: begin
                if (!w_dreq || w_access) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Starvation counter: counts data grants taken while a fetch waits
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_starve_cnt <= '0;
        end else if (r_state == IDLE) begin
            if (w_next_state == DGRANT && iREN) begin
                if (r_starve_cnt < STARVE_LIM) begin
                    r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
                end
            end else if (w_next_state != IDLE) begin
                r_starve_cnt <= '0;
            end
        end
    end

    // Outputs: Moore by state, except wait/load which react to ACCESS.
    // A dropped request (abort) lowers the strobes in the same cycle and
    // never signals completion.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        owner    = r_state;
        case (r_state)
            IDLE: begin
                iwait = iREN;
                dwait = w_dreq;
            end
            IGRANT: begin
                ramaddr = iaddr;
                if (iREN) begin
                    ramREN = 1'b1;
                    if (w_access) begin
                        iwait = 1'b0;
                        iload = ramload;
                    end
                end
            end
            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                if (w_dreq) begin
                    ramWEN = dWEN;
                    ramREN = dREN & ~dWEN;
                    if (w_access) begin
                        dwait = 1'b0;
                        dload = ramload;
                    end
                end
            end
            default: begin
                ramREN = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: RAM responder model, scoreboard of
// expected completions, a transaction table and hand-written corner sequences.
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    logic       CLK;
    logic       nRST;
    logic       iREN;
    word_t      iaddr;
    logic       iwait;
    word_t      iload;
    logic       dREN;
    logic       dWEN;
    word_t      daddr;
    word_t      dstore;
    logic       dwait;
    word_t      dload;
    logic       ramREN;
    logic       ramWEN;
    word_t      ramaddr;
    word_t      ramstore;
    word_t      ramload;
    ramstate_t  ramstate;
    logic [1:0] owner;

    memory_arbiter #(.STARVE_MAX(4)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .owner    (owner)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // RAM contents model: every address holds a distinct nonzero word
    function automatic word_t ram_data(input word_t a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    assign ramload = ram_data(ramaddr);

    // RAM responder: BUSY for busy_cfg strobed cycles, then ACCESS
    logic        rs_manual;
    ramstate_t   rs_man;
    int unsigned busy_cfg;
    int unsigned run_cnt;

    always_comb begin
        if (rs_manual) begin
            ramstate = rs_man;
        end else if (ramREN || ramWEN) begin
            ramstate = (run_cnt >= busy_cfg) ? ACCESS : BUSY;
        end else begin
            ramstate = FREE;
        end
    end

    always @(posedge CLK) begin
        if ((ramREN || ramWEN) && ramstate != ACCESS) run_cnt <= run_cnt + 1;
        else run_cnt <= 0;
    end

    int n_tests;
    int n_fail;

    typedef struct {
        bit    is_d;
        bit    is_write;
        word_t addr;
        word_t store;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        bit          iren;
        bit          dren;
        bit          dwen;
        word_t       iaddr;
        word_t       daddr;
        word_t       dstore;
        int unsigned busy;
        bit          d_first;
        int          lat_i;
        int          lat_d;
    } vec_t;
    vec_t vecs[6];
    vec_t v;

    bit  i_pend;
    bit  d_pend;
    bit  d_sticky;
    int  cyc;
    int  lat_i;
    int  lat_d;
    int  d_cnt;
    ramstate_t script[5];

    task automatic check(input string name, input word_t act, input word_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic on_complete(input bit is_d);
        exp_t e;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_completion: side=%0d but nothing expected", is_d);
            return;
        end
        e = sb.pop_front();
        if (e.is_d != is_d) begin
            n_fail++;
            $display("FAIL comp_side: got side %0d expected side %0d", is_d, e.is_d);
            return;
        end
        if (!is_d) begin
            check("iload", iload, ram_data(e.addr));
            check("i_ramaddr", ramaddr, e.addr);
            check1("i_ramREN", ramREN, 1'b1);
            check1("i_ramWEN", ramWEN, 1'b0);
            check1("i_dwait", dwait, 1'b1);
        end else begin
            check("dload", dload, ram_data(e.addr));
            check("d_ramaddr", ramaddr, e.addr);
            check1("d_ramWEN", ramWEN, e.is_write);
            check1("d_ramREN", ramREN, !e.is_write);
            check1("d_iwait", iwait, 1'b1);
            if (e.is_write) check("d_ramstore", ramstore, e.store);
        end
    endtask

    // One clock: sample at negedge, then advance to just after the posedge
    task automatic step();
        bit ic;
        bit dc;
        @(negedge CLK);
        cyc++;
        ic = iREN && !iwait;
        dc = (dREN || dWEN) && !dwait;
        if (ic) begin
            on_complete(1'b0);
            if (lat_i == 0) lat_i = cyc;
            i_pend = 1'b0;
            if (d_sticky) d_pend = 1'b0;
        end else begin
            check("iload_zero", iload, '0);
        end
        if (dc) begin
            on_complete(1'b1);
            if (lat_d == 0) lat_d = cyc;
            d_cnt++;
            if (!d_sticky) d_pend = 1'b0;
        end else begin
            check("dload_zero", dload, '0);
        end
        @(posedge CLK);
        #1;
        if (!i_pend) iREN = 1'b0;
        if (!d_pend) begin
            dREN = 1'b0;
            dWEN = 1'b0;
        end
    endtask

    task automatic run_until_done(input int budget);
        cyc   = 0;
        lat_i = 0;
        lat_d = 0;
        d_cnt = 0;
        while ((i_pend || d_pend) && cyc < budget) step();
        n_tests++;
        if (i_pend || d_pend) begin
            n_fail++;
            $display("FAIL txn_timeout: pending i=%0d d=%0d after %0d cycles", i_pend, d_pend, cyc);
            i_pend = 1'b0;
            d_pend = 1'b0;
            iREN   = 1'b0;
            dREN   = 1'b0;
            dWEN   = 1'b0;
            step();
        end
        check_int("sb_empty", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rs_manual = 1'b0;
        rs_man    = FREE;
        busy_cfg  = 0;
        d_sticky  = 1'b0;
        i_pend    = 1'b0;
        d_pend    = 1'b0;
        iaddr     = '0;
        daddr     = '0;
        dstore    = '0;
        dREN      = 1'b0;
        dWEN      = 1'b0;
        iREN      = 1'b1;
        nRST      = 1'b0;

        //            iren dren dwen iaddr         daddr       dstore        busy dfirst lat_i lat_d
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0,      32'h0,        0, 1'b0, 2, 0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h0000_0044, 32'h100,    32'hDEAD_BEEF, 0, 1'b1, 4, 2};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h200,    32'h0,        2, 1'b0, 0, 4};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h0,         32'h300,    32'h1234_5678, 1, 1'b0, 0, 3};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h0000_0080, 32'h400,    32'h0,        1, 1'b1, 6, 3};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,      32'h0,        3, 1'b0, 5, 0};

        script[0] = BUSY;
        script[1] = BUSY;
        script[2] = BUSY;
        script[3] = ERROR;
        script[4] = ACCESS;

        // Reset values, with a fetch request present
        #2;
        check1("rst_ramREN", ramREN, 1'b0);
        check1("rst_ramWEN", ramWEN, 1'b0);
        check("rst_ramaddr", ramaddr, '0);
        check("rst_ramstore", ramstore, '0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_iload", iload, '0);
        check("rst_dload", dload, '0);
        check1("rst_iwait", iwait, 1'b1);
        check1("rst_dwait", dwait, 1'b0);
        @(negedge CLK);
        iREN = 1'b0;
        nRST = 1'b1;
        @(negedge CLK);
        check1("idle_iwait", iwait, 1'b0);
        check1("idle_dwait", dwait, 1'b0);
        check("idle_owner", 32'(owner), 32'd0);
        check1("idle_ramREN", ramREN, 1'b0);
        @(posedge CLK);
        #1;

        // Starvation: fetch held, data request held continuously
        busy_cfg = 0;
        for (int k = 0; k < 4; k++) sb.push_back('{1'b1, 1'b0, 32'h600, 32'h0});
        sb.push_back('{1'b0, 1'b0, 32'h700, 32'h0});
        iaddr    = 32'h700;
        daddr    = 32'h600;
        iREN     = 1'b1;
        dREN     = 1'b1;
        i_pend   = 1'b1;
        d_pend   = 1'b1;
        d_sticky = 1'b1;
        run_until_done(40);
        d_sticky = 1'b0;
        check_int("starve_d_count", d_cnt, 4);
        check_int("starve_lat_i", lat_i, 10);
        check_int("starve_lat_d", lat_d, 2);

        // Transaction table; data-first expectations also prove the
        // starvation counter was cleared by the forced fetch grant
        foreach (vecs[k]) begin
            v = vecs[k];
            busy_cfg = v.busy;
            if (v.iren && (v.dren || v.dwen)) begin
                if (v.d_first) begin
                    sb.push_back('{1'b1, v.dwen, v.daddr, v.dstore});
                    sb.push_back('{1'b0, 1'b0, v.iaddr, 32'h0});
                end else begin
                    sb.push_back('{1'b0, 1'b0, v.iaddr, 32'h0});
                    sb.push_back('{1'b1, v.dwen, v.daddr, v.dstore});
                end
            end else if (v.iren) begin
                sb.push_back('{1'b0, 1'b0, v.iaddr, 32'h0});
            end else begin
                sb.push_back('{1'b1, v.dwen, v.daddr, v.dstore});
            end
            iaddr  = v.iaddr;
            daddr  = v.daddr;
            dstore = v.dstore;
            iREN   = v.iren;
            dREN   = v.dren;
            dWEN   = v.dwen;
            i_pend = v.iren;
            d_pend = v.dren | v.dwen;
            run_until_done(40);
            check_int($sformatf("v%0d_lat_i", k), lat_i, v.lat_i);
            check_int($sformatf("v%0d_lat_d", k), lat_d, v.lat_d);
        end

        // Data read: BUSY x3, ERROR, ACCESS
        rs_manual = 1'b1;
        rs_man    = FREE;
        daddr     = 32'h80;
        dREN      = 1'b1;
        @(negedge CLK);
        check1("retry_idle_dwait", dwait, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(posedge CLK);
            #1;
            rs_man = script[k];
            @(negedge CLK);
            check1($sformatf("retry%0d_dwait", k), dwait, (k != 4));
            check1($sformatf("retry%0d_ramREN", k), ramREN, 1'b1);
            check("retry_owner", 32'(owner), 32'd2);
            check($sformatf("retry%0d_dload", k), dload, (k == 4) ? ram_data(32'h80) : 32'h0);
        end
        @(posedge CLK);
        #1;
        dREN   = 1'b0;
        rs_man = FREE;
        @(negedge CLK);
        check("retry_after_owner", 32'(owner), 32'd0);
        @(posedge CLK);
        #1;

        // Reset during a stalled fetch
        rs_man = BUSY;
        iaddr  = 32'h44;
        iREN   = 1'b1;
        @(negedge CLK);
        check("rfetch_idle_owner", 32'(owner), 32'd0);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        check("rfetch_owner", 32'(owner), 32'd1);
        check1("rfetch_ramREN", ramREN, 1'b1);
        check("rfetch_ramaddr", ramaddr, 32'h44);
        #2;
        nRST = 1'b0;
        #1;
        check1("async_ramREN", ramREN, 1'b0);
        check("async_owner", 32'(owner), 32'd0);
        check("async_ramaddr", ramaddr, '0);
        check1("async_iwait", iwait, 1'b1);
        @(posedge CLK);
        #1;
        check("inrst_owner", 32'(owner), 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            check1($sformatf("post_rst%0d_iwait", k), iwait, 1'b1);
            check($sformatf("post_rst%0d_iload", k), iload, '0);
        end
        // Fetch dropped while stalled: abort
        @(posedge CLK);
        #1;
        iREN = 1'b0;
        @(negedge CLK);
        check1("iabort_ramREN", ramREN, 1'b0);
        check("iabort_owner", 32'(owner), 32'd1);
        check("iabort_iload", iload, '0);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        check("iabort_next_owner", 32'(owner), 32'd0);
        @(posedge CLK);
        #1;

        // Data read dropped mid-grant, RAM answering ACCESS that cycle
        rs_man = BUSY;
        daddr  = 32'h500;
        dREN   = 1'b1;
        @(negedge CLK);
        check1("dabort_idle_dwait", dwait, 1'b1);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        check("dabort_grant_owner", 32'(owner), 32'd2);
        check1("dabort_grant_ramREN", ramREN, 1'b1);
        check("dabort_grant_ramaddr", ramaddr, 32'h500);
        check1("dabort_grant_dwait", dwait, 1'b1);
        @(posedge CLK);
        #1;
        dREN   = 1'b0;
        rs_man = ACCESS;
        @(negedge CLK);
        check1("dabort_ramREN", ramREN, 1'b0);
        check1("dabort_ramWEN", ramWEN, 1'b0);
        check("dabort_owner", 32'(owner), 32'd2);
        check1("dabort_dwait", dwait, 1'b1);
        check("dabort_dload", dload, '0);
        @(posedge CLK);
        #1;
        rs_man = FREE;
        @(negedge CLK);
        check("dabort_next_owner", 32'(owner), 32'd0);
        @(posedge CLK);
        #1;
        rs_manual = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter: STARVE_MAX, 4, number of consecutive data grants made while iREN is pending before the instruction side is forced a grant.
REQ-002 CLK  in  1  single system clock; all state updates on its rising edge.
REQ-003 nRST  in  1  reset, asynchronous and active-low.
REQ-004 iREN  in  1  instruction read request.
REQ-005 iaddr  in  32  instruction word address.
REQ-006 iwait  out  1  instruction side stalled; low for exactly the completion cycle.
REQ-007 iload  out  32  instruction data; valid when iwait low.
REQ-008 dREN  in  1  data read request.
REQ-009 dWEN  in  1  data write request.
REQ-010 daddr  in  32  data address.
REQ-011 dstore  in  32  data write value.
REQ-012 dwait  out  1  data side stalled; low for exactly the completion cycle.
REQ-013 dload  out  32  data read value; valid when dwait low.
REQ-014 ramREN / ramWEN  out  1 each  RAM read / write strobes.
REQ-015 ramaddr / ramstore  out  32 each  RAM address / write data.
REQ-016 ramload  in  32  RAM read data.
REQ-017 ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
REQ-018 owner  out  2  current state encoding, for debug and hazard unit.

Function
REQ-019 FSM states SHALL be IDLE, IGRANT, DGRANT; outputs Moore except wait/load on completion.
REQ-020 IDLE: ram strobes low, iwait=iREN, dwait=(dREN|dWEN); arbitrate and move to a grant state next cycle; no requests -> stay IDLE.
REQ-021 Arbitration: data (dREN|dWEN) wins over iREN, unless starve_cnt==STARVE_MAX and iREN high, then IGRANT.
REQ-022 starve_cnt (3 bits, saturating at STARVE_MAX): +1 on DGRANT entry with iREN high; cleared on IGRANT entry or on any grant with iREN low.
REQ-023 IGRANT: ramREN=1, ramaddr=iaddr, dwait=1; iwait=0 and iload=ramload in the cycle ramstate==ACCESS, else iwait=1.
REQ-024 DGRANT: ramaddr=daddr, ramstore=dstore; ramWEN=dWEN, ramREN=dREN&~dWEN (write wins if both); iwait=1; dwait=0 and dload=ramload when ramstate==ACCESS.
REQ-025 Completion cycle (ACCESS in a grant state) -> IDLE next cycle; one-cycle bubble is mandatory, so a still-asserted request is not re-granted twice.
REQ-026 ramstate BUSY or FREE in a grant state: hold state and outputs; ERROR: hold and retry, wait stays high.
REQ-027 Requester drops its request before ACCESS: abort, strobes low that cycle, IDLE next cycle, no completion signalled.
REQ-028 Minimum latency request->completion: 2 cycles (IDLE grant edge, then ACCESS on first grant cycle).
REQ-029 Outside completion, iload and dload SHALL be 0.

Reset
REQ-030 On nRST low, immediately: state=IDLE, starve_cnt=0; ramREN=ramWEN=0, ramaddr=ramstore=0, owner=0, iload=dload=0; iwait/dwait follow IDLE rule.
REQ-031 Reset asserted mid-transaction SHALL abandon it; no completion is signalled for it after release.

Structure
REQ-032 ramstate_t and word_t come from cpu_types_pkg; arb_state_t (IDLE/IGRANT/DGRANT) SHALL be added there.
REQ-033 Single module, no sub-modules; starvation counter inline.

Verification
REQ-034 iREN=1, iaddr=0x40, ramstate ACCESS on first grant cycle -> ramREN high one cycle, iwait low in cycle 2, iload=ramload.
REQ-035 iREN=1 and dWEN=1, daddr=0x100, dstore=0xDEADBEEF -> DGRANT first, ramWEN=1 with those values; IGRANT after one IDLE bubble.
REQ-036 iREN held, dREN re-asserted continuously, STARVE_MAX=4 -> 4 data completions then IGRANT; starve_cnt back to 0.
REQ-037 DGRANT, ramstate BUSY 3 cycles then ERROR 1 then ACCESS -> dwait high 4 cycles, low on 5th, single completion.
REQ-038 nRST pulsed low during IGRANT with ramstate BUSY -> strobes 0 asynchronously, IDLE after release, no iwait-low pulse for the aborted fetch.
REQ-039 dREN dropped mid-DGRANT -> strobes low that cycle, IDLE next, dwait never low.
